fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port count  input  32  current PC from the PC register.
REQ-005 SHALL provide port count_next  output  32  next PC to the PC register.
REQ-006 SHALL provide port imem_req  output  1  instruction-memory read request.
REQ-007 SHALL provide port imem_addr  output  32  request address; equals count.
REQ-008 SHALL provide port imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-009 SHALL provide ports redirect  input  1 and redirect_pc  input  32  branch/jump redirect.
REQ-010 SHALL provide ports instr_valid  output  1, instr  output  32, instr_pc  output  32  decode-side entry.
REQ-011 SHALL provide port instr_ready  input  1  decode accepts entry.

Function
REQ-012 SHALL track occupancy (0..DEPTH) and one in-flight flag plus in-flight PC.
REQ-013 SHALL assert imem_req when redirect=0, rst=0 and occupancy + inflight < DEPTH (registered values, pre-pop).
REQ-014 SHALL drive count_next = {redirect_pc[31:2],2'b00} if redirect; else count+4 (mod 2^32) if imem_req; else count.
REQ-015 SHALL set inflight=1 and capture count as inflight PC on the cycle after imem_req=1; otherwise inflight=0.
REQ-016 SHALL write {imem_rdata, inflight PC} into the queue tail when inflight=1 and redirect=0.
REQ-017 SHALL present the head entry on instr/instr_pc with instr_valid=1 whenever occupancy>0 and redirect=0.
REQ-018 SHALL dequeue on instr_valid & instr_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-019 SHALL preserve FIFO order; pointers SHALL wrap modulo DEPTH.
REQ-020 SHALL never overflow: push with occupancy=DEPTH is unreachable by REQ-013 (assertion-checked).
REQ-021 SHALL, on redirect=1, flush the queue (occupancy and pointers to 0 next cycle), discard any response arriving that cycle, clear inflight, force instr_valid=0, and issue no request.
REQ-022 SHALL keep instr/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-023 SHALL give a latency of 2 cycles from imem_req to instr_valid when bypass is disabled.

Reset
REQ-024 SHALL, while rst=1, hold occupancy=0, pointers=0, inflight=0, inflight PC=0.
REQ-025 SHALL, while rst=1, drive instr_valid=0, imem_req=0, count_next=count; instr and instr_pc SHALL be 0.
REQ-026 SHALL, on rst asserted mid-operation, drop all queued and in-flight entries immediately and not wait for a clock edge.

Configuration
REQ-027 SHALL compile FETCH_QUEUE_BYPASS_EN: when defined, if occupancy=0 and inflight=1 and redirect=0, instr_valid=1 with instr=imem_rdata and instr_pc=inflight PC in the same cycle; the entry is not written if accepted and is written if not accepted. Latency is 1 cycle.
REQ-028 SHALL, without FETCH_QUEUE_BYPASS_EN, always route responses through the queue as in REQ-023.

Verification
REQ-029 Reset release, count=0x0, instr_ready=1, imem_rdata=0x00500093 -> imem_req=1 at cycle 0, count_next=0x4; instr_valid=1, instr_pc=0x0 at cycle 2 (cycle 1 with bypass).
REQ-030 instr_ready=0 from reset, DEPTH=4 -> exactly 4 requests (PCs 0x0,0x4,0x8,0xC), then imem_req=0 and count_next=count=0x10; occupancy 4.
REQ-031 Full queue, then instr_ready=1 for 4 cycles -> instr_pc 0x0,0x4,0x8,0xC in order; requests resume as occupancy drops.
REQ-032 Redirect=1, redirect_pc=0x00000103 with 2 queued and 1 in flight -> count_next=0x100, instr_valid=0 next cycle, first subsequent instr_pc=0x100.
REQ-033 count=0xFFFFFFFC with a request -> count_next=0x00000000.
REQ-034 rst pulsed asynchronously between edges with 3 entries queued -> instr_valid and imem_req fall immediately; occupancy 0 after release.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential PC reads to instruction memory and buffers the responses for decode.
// Optional same-cycle response bypass to decode when the queue is empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] count,
   output logic [31:0] count_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [OW-1:0] FULL = OW'(DEPTH);

   logic [OW-1:0] occ_reg, occ_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic          inflight_reg, inflight_next;
   logic [31:0]   inflight_pc_reg, inflight_pc_next;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem [DEPTH];

   logic          queue_valid;
   logic          bypass_hit;
   logic          push;
   logic          pop;
   logic [OW:0]   pending;

   // Occupancy plus the outstanding read must leave room for the response that will come back.
   assign pending    = {1'b0, occ_reg} + {{OW{1'b0}}, inflight_reg};
   assign imem_req   = !rst && !redirect && (pending < {1'b0, FULL});
   assign imem_addr  = count;
   assign count_next = redirect ? (redirect_pc & 32'hFFFF_FFFC) :
                       imem_req ? (count + 32'd4) : count;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass_hit = !rst && !redirect && inflight_reg && (occ_reg == '0);
`else
   assign bypass_hit = 1'b0;
`endif

   assign queue_valid = !rst && !redirect && (occ_reg != '0);
   assign instr_valid = queue_valid || bypass_hit;
   assign instr       = rst ? 32'd0 : (bypass_hit ? imem_rdata      : data_mem[rd_ptr_reg]);
   assign instr_pc    = rst ? 32'd0 : (bypass_hit ? inflight_pc_reg : pc_mem[rd_ptr_reg]);

   // A bypassed response consumed by decode this cycle never enters the queue.
   assign push = !rst && !redirect && inflight_reg && !(bypass_hit && instr_ready);
   assign pop  = queue_valid && instr_ready;

   always_comb begin
      occ_next         = occ_reg;
      rd_ptr_next      = rd_ptr_reg;
      wr_ptr_next      = wr_ptr_reg;
      inflight_next    = imem_req;
      inflight_pc_next = imem_req ? count : inflight_pc_reg;
      if (redirect) begin
         occ_next    = '0;
         rd_ptr_next = '0;
         wr_ptr_next = '0;
      end else begin
         if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
         if (push && !pop)      occ_next = occ_reg + OW'(1);
         else if (pop && !push) occ_next = occ_reg - OW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_reg         <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
      end else begin
         occ_reg         <= occ_next;
         rd_ptr_reg      <= rd_ptr_next;
         wr_ptr_reg      <= wr_ptr_next;
         inflight_reg    <= inflight_next;
         inflight_pc_reg <= inflight_pc_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (push) begin
         data_mem[wr_ptr_reg] <= imem_rdata;
         pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
      end
   end

   // The request throttle guarantees a returning response always has a free slot.
   assert property (@(posedge clk) disable iff (rst) !(push && occ_reg == FULL));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: models the PC register and a one-cycle instruction memory around the DUT.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic [31:0] count;
   logic [31:0] count_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int checks = 0;
   int errors = 0;
   int nreq;

   fetch_queue #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .count      (count),
      .count_next (count_next),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_ready(instr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return 32'h0050_0093 ^ {pc[23:0], 8'h00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
      $display("check %-18s observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // One clock: latch the PC register and return read data for any request made this cycle.
   task automatic cycle();
      logic [31:0] cn, ad;
      logic        rq;
      #1;
      cn = count_next;
      rq = imem_req;
      ad = imem_addr;
      @(posedge clk);
      #1;
      count      = cn;
      imem_rdata = rq ? mem_word(ad) : 32'hDEAD_BEEF;
      #1;
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      rst        = 1'b1;
      redirect   = 1'b0;
      count      = start_pc;
      imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; count = 32'h40; imem_rdata = 32'd0;
      redirect = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b1;
      #2;
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_count_next", count_next, 32'h40);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);

      // First fetch latency
      do_reset(32'h0);
      chk("c0_req", imem_req, 1);
      chk("c0_addr", imem_addr, 32'h0);
      chk("c0_count_next", count_next, 32'h4);
      cycle();
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("c1_valid", instr_valid, 1);
      chk("c1_instr_pc", instr_pc, 32'h0);
      chk("c1_instr", instr, 32'h0050_0093);
      cycle();
      chk("c2_instr_pc", instr_pc, 32'h4);
`else
      chk("c1_valid", instr_valid, 0);
      chk("c1_count_next", count_next, 32'h8);
      cycle();
      chk("c2_valid", instr_valid, 1);
      chk("c2_instr_pc", instr_pc, 32'h0);
      chk("c2_instr", instr, 32'h0050_0093);
`endif

      // Fill with decode stalled: exactly DEPTH requests, head held stable
      instr_ready = 1'b0;
      do_reset(32'h0);
      nreq = 0;
      for (int c = 0; c < 8; c++) begin
         if (imem_req) begin
            chk("fill_addr", imem_addr, 32'(nreq * 4));
            nreq++;
         end
         if (c >= 2) begin
            chk("fill_hold_pc", instr_pc, 32'h0);
            chk("fill_hold_instr", instr, mem_word(32'h0));
         end
         cycle();
      end
      chk("fill_nreq", 32'(nreq), 32'd4);
      chk("full_req", imem_req, 0);
      chk("full_count_next", count_next, 32'h10);

      // Drain in order; requests resume as room appears
      instr_ready = 1'b1;
      for (int d = 0; d < 4; d++) begin
         chk("drain_valid", instr_valid, 1);
         chk("drain_pc", instr_pc, 32'(d * 4));
         chk("drain_instr", instr, mem_word(32'(d * 4)));
         chk("drain_req", imem_req, (d >= 1) ? 32'd1 : 32'd0);
         if (d >= 1) chk("drain_addr", imem_addr, 32'(32'h10 + (d - 1) * 4));
         cycle();
      end

      // Redirect with two queued and one in flight
      instr_ready = 1'b0;
      #1;
      chk("pre_redir_valid", instr_valid, 1);
      chk("pre_redir_pc", instr_pc, 32'h10);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      #1;
      chk("redir_count_next", count_next, 32'h100);
      chk("redir_req", imem_req, 0);
      chk("redir_valid", instr_valid, 0);
      cycle();
      redirect = 1'b0;
      #1;
      chk("post_redir_valid", instr_valid, 0);
      chk("post_redir_req", imem_req, 1);
      chk("post_redir_addr", imem_addr, 32'h100);
      cycle();
`ifndef FETCH_QUEUE_BYPASS_EN
      chk("post_redir_valid2", instr_valid, 0);
      cycle();
`endif
      chk("redir_first_valid", instr_valid, 1);
      chk("redir_first_pc", instr_pc, 32'h100);
      chk("redir_first_instr", instr, mem_word(32'h100));

      // PC wrap at the top of the address space
      instr_ready = 1'b1;
      do_reset(32'hFFFF_FFFC);
      chk("wrap_req", imem_req, 1);
      chk("wrap_count_next", count_next, 32'h0);
      cycle();
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_count_next2", count_next, 32'h4);
`ifndef FETCH_QUEUE_BYPASS_EN
      cycle();
`endif
      chk("wrap_valid", instr_valid, 1);
      chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_instr", instr, mem_word(32'hFFFF_FFFC));

      // Asynchronous reset pulse between clock edges with three entries queued
      instr_ready = 1'b0;
      do_reset(32'h0);
      repeat (6) cycle();
      instr_ready = 1'b1;
      cycle();
      instr_ready = 1'b0;
      #1;
      chk("occ3_valid", instr_valid, 1);
      chk("occ3_pc", instr_pc, 32'h4);
      chk("occ3_req", imem_req, 1);
      chk("occ3_addr", imem_addr, 32'h10);
      rst = 1'b1;
      #1;
      chk("arst_valid", instr_valid, 0);
      chk("arst_req", imem_req, 0);
      chk("arst_count_next", count_next, 32'h10);
      chk("arst_instr_pc", instr_pc, 32'h0);
      chk("arst_instr", instr, 32'h0);
      rst = 1'b0;
      #1;
      chk("arel_valid", instr_valid, 0);
      chk("arel_req", imem_req, 1);
      chk("arel_addr", imem_addr, 32'h10);
      instr_ready = 1'b1;
      cycle();
`ifndef FETCH_QUEUE_BYPASS_EN
      chk("arel_valid1", instr_valid, 0);
      cycle();
`endif
      chk("arel_first_valid", instr_valid, 1);
      chk("arel_first_pc", instr_pc, 32'h10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
